// File: rtl/ifetch_if.sv
// ifetch_if: ROM address/data, redirect and decode valid/ready signals of the fetch stage.
interface ifetch_if;
  logic [29:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  modport master (
    output imem_addr, out_valid, out_pc, out_inst,
    input  imem_inst, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_addr, out_valid, out_pc, out_inst,
    output imem_inst, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/ifetch_stage.sv
// ifetch_stage: PC and ROM fetch feeding a {pc, inst} FIFO with redirect flush.
// Define IFETCH_BYPASS_EN to let a response into an empty FIFO reach out_* in the same cycle.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0] pc, inflight_pc, redirect_base;
  logic inflight, issue, resp, push, pop, has_data, byp;
  logic [AW:0] count;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] mem_pc [FIFO_DEPTH];
  logic [31:0] mem_inst [FIFO_DEPTH];
  assign redirect_base = bus.redirect_pc & 32'hFFFF_FFFC;
  assign has_data = count != '0;
  // Slots already promised to an in-flight fetch count as occupied, so a push never overflows.
  assign issue = int'(count) + int'(inflight) < FIFO_DEPTH;
  assign resp = inflight & ~bus.redirect_valid;
`ifdef IFETCH_BYPASS_EN
  assign byp = resp & ~has_data;
`else
  assign byp = 1'b0;
`endif
  assign bus.out_valid = (has_data | byp) & ~bus.redirect_valid;
  assign bus.out_pc = has_data ? mem_pc[rd_ptr] : byp ? inflight_pc : '0;
  assign bus.out_inst = has_data ? mem_inst[rd_ptr] : byp ? bus.imem_inst : '0;
  assign pop = bus.out_valid & bus.out_ready & has_data;
  assign push = resp & ~(byp & bus.out_ready);
  assign bus.imem_addr = bus.redirect_valid ? redirect_base[31:2] : pc[31:2];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= {RESET_PC[31:2], 2'b00};
      inflight <= 1'b0;
      inflight_pc <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bus.redirect_valid) begin
      pc <= redirect_base + 32'd4;
      inflight <= 1'b1;
      inflight_pc <= redirect_base;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc <= pc + 32'd4;
        inflight_pc <= pc;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_pc[wr_ptr] <= inflight_pc;
      mem_inst[wr_ptr] <= bus.imem_inst;
    end
endmodule

// File: tb/tb_ifetch_stage.sv
// tb_ifetch_stage: directed scenarios against a registered ROM image for ifetch_stage.
module tb_ifetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_pc;
`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  ifetch_if bus();
  ifetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] rom(input logic [29:0] a);
    case (a)
      30'h00:  rom = 32'h3c1d1000;
      30'h01:  rom = 32'h0c001403;
      30'h02:  rom = 32'h37bd7000;
      30'h14:  rom = 32'h356b00c8;
      30'h15:  rom = 32'h3c0f1f00;
      default: rom = {a, 2'b11} ^ 32'h5a00_0000;
    endcase
  endfunction
  always @(posedge clk) bus.imem_inst <= rom(bus.imem_addr);
  task cyc;
    @(posedge clk);
    #1;
  endtask
  task do_reset;
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    cyc;
    cyc;
    rst = 1'b0;
  endtask
  task test_reset;
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    rst = 1'b1;
    cyc;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_inst} !== 65'b0) begin
      failures++;
      $display("FAIL reset_out got v=%b pc=%h inst=%h exp all zero", bus.out_valid, bus.out_pc, bus.out_inst);
    end
    checks++;
    if (bus.imem_addr !== 30'h0) begin
      failures++;
      $display("FAIL reset_addr got %h exp 0", bus.imem_addr);
    end
  endtask
  task test_stream;
    bus.out_ready = 1'b1;
    do_reset;
    #1;
    for (int c = 0; c < 6; c++) begin
      exp_pc = 32'((c - LAT) * 4);
      checks++;
      if (c >= LAT ? ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, exp_pc, rom(exp_pc[31:2])}) : (bus.out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL stream c=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h", c, bus.out_valid, bus.out_pc, bus.out_inst, c >= LAT, exp_pc);
      end
      cyc;
      #1;
    end
  endtask
  task test_backpressure;
    bus.out_ready = 1'b0;
    do_reset;
    repeat (8) cyc;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, 32'h0, 32'h3c1d1000}) begin
      failures++;
      $display("FAIL bp_head got v=%b pc=%h inst=%h exp v=1 pc=0 inst=3c1d1000", bus.out_valid, bus.out_pc, bus.out_inst);
    end
    checks++;
    if (bus.imem_addr !== 30'h4) begin
      failures++;
      $display("FAIL bp_pc_hold got addr=%h exp 4", bus.imem_addr);
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_pc = 32'(k * 4);
      checks++;
      if ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, exp_pc, rom(exp_pc[31:2])}) begin
        failures++;
        $display("FAIL bp_drain k=%0d got v=%b pc=%h inst=%h exp pc=%h", k, bus.out_valid, bus.out_pc, bus.out_inst, exp_pc);
      end
      cyc;
      #1;
    end
  endtask
  task test_redirect_full;
    bus.out_ready = 1'b0;
    do_reset;
    repeat (8) cyc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h50;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 30'h14) begin
      failures++;
      $display("FAIL redir_full_cycle got v=%b addr=%h exp v=0 addr=14", bus.out_valid, bus.imem_addr);
    end
    cyc;
    bus.redirect_valid = 1'b0;
    #1;
    for (int c = 1; c < 5; c++) begin
      exp_pc = 32'h50 + 32'((c - LAT) * 4);
      checks++;
      if (c >= LAT ? ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, exp_pc, rom(exp_pc[31:2])}) : (bus.out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL redir_full c=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h", c, bus.out_valid, bus.out_pc, bus.out_inst, c >= LAT, exp_pc);
      end
      cyc;
      #1;
    end
  endtask
  task test_redirect_resp;
    bus.out_ready = 1'b1;
    do_reset;
    repeat (4) cyc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h53;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 30'h14) begin
      failures++;
      $display("FAIL redir_resp_cycle got v=%b addr=%h exp v=0 addr=14", bus.out_valid, bus.imem_addr);
    end
    cyc;
    bus.redirect_valid = 1'b0;
    #1;
    for (int c = 1; c < 5; c++) begin
      exp_pc = 32'h50 + 32'((c - LAT) * 4);
      checks++;
      if (c >= LAT ? ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, exp_pc, rom(exp_pc[31:2])}) : (bus.out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL redir_resp c=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h", c, bus.out_valid, bus.out_pc, bus.out_inst, c >= LAT, exp_pc);
      end
      cyc;
      #1;
    end
  endtask
  task test_reset_mid;
    bus.out_ready = 1'b0;
    do_reset;
    repeat (4) cyc;
    #1;
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, 32'h0, 32'h3c1d1000}) begin
      failures++;
      $display("FAIL mid_before got v=%b pc=%h inst=%h exp v=1 pc=0", bus.out_valid, bus.out_pc, bus.out_inst);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.imem_addr !== 30'h0) begin
      failures++;
      $display("FAIL mid_async got v=%b pc=%h addr=%h exp all zero", bus.out_valid, bus.out_pc, bus.imem_addr);
    end
    cyc;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      exp_pc = 32'((c - LAT) * 4);
      checks++;
      if (c >= LAT ? ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, exp_pc, rom(exp_pc[31:2])}) : (bus.out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL mid_restart c=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h", c, bus.out_valid, bus.out_pc, bus.out_inst, c >= LAT, exp_pc);
      end
      cyc;
      #1;
    end
  endtask
  task test_wrap;
    bus.out_ready = 1'b1;
    do_reset;
    repeat (3) cyc;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.imem_addr !== 30'h3FFF_FFFF) begin
      failures++;
      $display("FAIL wrap_cycle got v=%b addr=%h exp v=0 addr=3fffffff", bus.out_valid, bus.imem_addr);
    end
    cyc;
    bus.redirect_valid = 1'b0;
    #1;
    checks++;
    if (bus.imem_addr !== 30'h0) begin
      failures++;
      $display("FAIL wrap_next_pc got addr=%h exp 0", bus.imem_addr);
    end
    for (int c = 1; c < 5; c++) begin
      exp_pc = 32'hFFFF_FFFC + 32'((c - LAT) * 4);
      checks++;
      if (c >= LAT ? ({bus.out_valid, bus.out_pc, bus.out_inst} !== {1'b1, exp_pc, rom(exp_pc[31:2])}) : (bus.out_valid !== 1'b0)) begin
        failures++;
        $display("FAIL wrap c=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h", c, bus.out_valid, bus.out_pc, bus.out_inst, c >= LAT, exp_pc);
      end
      cyc;
      #1;
    end
  endtask
  initial begin
    bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_full;
    test_redirect_resp;
    test_reset_mid;
    test_wrap;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
